m8_error_monitor: RTL and testbench
===================================

Name: m8_error_monitor

Overview:
- Exhaustive error-characterisation engine that sits directly upstream and downstream of one 8x8 approximate recursive multiplier instance.
- Drives the multiplier's a/b operand inputs with a sweep of all 65,536 operand pairs.
- Takes the multiplier's combinational 16-bit product back in, computes the exact product internally, and accumulates error metrics.
- Used in synthesis-ready self-characterisation of approximate multiplier variants.

Parameters:
- ED_THRESH, default 0: an error is counted when error distance (ED) > ED_THRESH.
- SUM_W, default 32: width of the ED accumulator. Must be >= 32; 65536*65535 < 2^32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE
- op_a  output  8  operand a to the multiplier under test (registered)
- op_b  output  8  operand b to the multiplier under test (registered)
- approx_y  input  16  product returned combinationally by the multiplier for the current op_a/op_b
- busy  output  1  high in SWEEP and DRAIN
- done  output  1  high in DONE; held until the next accepted start or rst
- err_count  output  17  number of pairs with ED > ED_THRESH (max 65536)
- sum_ed  output  SUM_W  sum of ED over all pairs
- max_ed  output  16  largest ED seen
- max_a  output  8  op_a of the first pair reaching max_ed
- max_b  output  8  op_b of the first pair reaching max_ed

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (port rst, clock clk).
- Reset: state=IDLE. All outputs 0, including op_a, op_b, busy, done, err_count, sum_ed, max_ed, max_a, max_b. Pipeline valid bits cleared.
- Reset mid-sweep: same as above, taking effect at the next edge. In-flight pipeline data is discarded.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE with start=1 at cycle T:
  - next state SWEEP
  - accumulators and max fields cleared to 0
  - {op_a,op_b}=16'h0000
  - done=0
- start in SWEEP or DRAIN: ignored.
- SWEEP:
  - Presents pair k = {op_a,op_b} (op_b is the low byte) in cycle T+1+k, k=0..65535.
  - Counter increments by 1 each cycle.
  - When k=16'hFFFF is presented, next state is DRAIN. Counter wraps to 0 and op_a/op_b hold 0 after wrap.
- Pipeline (qualified by valid bits, 3 stages):
  - S1: captures approx_y, exact = op_a*op_b (16-bit unsigned), and op_a/op_b at the end of the presenting cycle.
  - S2: registers ED = |exact - approx_y| (16-bit unsigned; compute with a 17-bit difference, then magnitude).
  - S3 (accumulate):
    - sum_ed += ED
    - err_count += (ED > ED_THRESH)
    - if ED > max_ed: max_ed = ED, max_a/max_b = pair operands
    - Strict '>' keeps the first occurrence in sweep order.
- DRAIN: exactly 2 cycles, T+65537 and T+65538. Next state DONE.
- DONE:
  - Entered at T+65539; all results final and stable from that cycle.
  - busy=0, done=1.
- busy: 1 from T+1 through T+65538.
- Results are not cleared on entering DONE. They are cleared only by an accepted start or rst.
- No saturation logic is required; widths are sized for the worst case.

Test Plan:
- approx_y driven by an exact behavioural product -> done at T+65539; err_count=0, sum_ed=0, max_ed=0, max_a=max_b=0.
- approx_y = exact product with bit0 forced to 0 -> err_count=16384, sum_ed=16384, max_ed=1, max_a=1, max_b=1.
- approx_y tied to 0 -> err_count=65025, sum_ed=1065369600, max_ed=65025, max_a=255, max_b=255.
- ED_THRESH=1, bit0-forced stub -> err_count=0, sum_ed=16384, max_ed=1.
- start pulsed again at T+100 during SWEEP -> ignored; results identical to the single-start run.
- rst asserted at T+30000 -> next cycle all outputs 0 and state IDLE; a fresh start then completes with correct totals.

Source files
------------

// File: rtl/m8_error_monitor.sv
// m8_error_monitor
// Exhaustive error-characterisation engine for one 8x8 approximate multiplier.
// Sweeps all 65536 operand pairs on op_a/op_b, takes the combinational product
// back on approx_y, compares against the exact product and accumulates error
// count, summed error distance, and the first pair reaching the largest error.
module m8_error_monitor #(
  parameter int unsigned ED_THRESH = 0,
  parameter int unsigned SUM_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [7:0]       op_a,
  output logic [7:0]       op_b,
  input  logic [15:0]      approx_y,
  output logic             busy,
  output logic             done,
  output logic [16:0]      err_count,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic        drain_cnt;
  logic        accept;

  logic        v1;
  logic [15:0] exact1;
  logic [15:0] approx1;
  logic [7:0]  a1;
  logic [7:0]  b1;

  logic        v2;
  logic [15:0] ed2;
  logic [7:0]  a2;
  logic [7:0]  b2;

  logic [16:0] diff;
  logic [15:0] ed_next;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state == S_SWEEP) || (state == S_DRAIN);
  assign done   = (state == S_DONE);

  // Magnitude of the 17-bit exact-minus-approx difference.
  always_comb begin
    diff    = {1'b0, exact1} - {1'b0, approx1};
    ed_next = diff[16] ? (~diff[15:0] + 16'd1) : diff[15:0];
  end

  // Control FSM and operand sweep counter; DRAIN lasts two cycles to flush S2/S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_SWEEP;
            {op_a, op_b} <= '0;
          end
        end
        S_SWEEP: begin
          {op_a, op_b} <= {op_a, op_b} + 16'd1;
          if ({op_a, op_b} == 16'hFFFF) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        default: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_DONE;
        end
      endcase
    end
  end

  // S1 captures the presented pair, S2 registers its error distance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      exact1  <= '0;
      approx1 <= '0;
      a1      <= '0;
      b1      <= '0;
      ed2     <= '0;
      a2      <= '0;
      b2      <= '0;
    end else begin
      v1      <= (state == S_SWEEP);
      exact1  <= 16'(op_a) * 16'(op_b);
      approx1 <= approx_y;
      a1      <= op_a;
      b1      <= op_b;
      v2      <= v1;
      ed2     <= ed_next;
      a2      <= a1;
      b2      <= b1;
    end
  end

  // S3 accumulates metrics; strict '>' keeps the first maximum in sweep order.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
      max_a     <= '0;
      max_b     <= '0;
    end else if (v2) begin
      sum_ed    <= sum_ed + SUM_W'(ed2);
      err_count <= err_count + {16'd0, (32'(ed2) > ED_THRESH)};
      if (ed2 > max_ed) begin
        max_ed <= ed2;
        max_a  <= a2;
        max_b  <= b2;
      end
    end
  end

endmodule

// File: tb/tb_m8_error_monitor.sv
// Directed bench for m8_error_monitor. Five instances sweep in parallel, each
// fed by a different multiplier stub:
//   0: exact product            (ED_THRESH=0)
//   1: exact with bit0 cleared  (ED_THRESH=0)
//   2: exact with bit0 cleared  (ED_THRESH=1)
//   3: tied to 0                (ED_THRESH=0)
//   4: tied to 16'hFFFF         (ED_THRESH=0), approx always above exact
module tb_m8_error_monitor;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;

  logic [7:0]  op_a      [N];
  logic [7:0]  op_b      [N];
  logic [15:0] approx_y  [N];
  logic        busy      [N];
  logic        done      [N];
  logic [16:0] err_count [N];
  logic [31:0] sum_ed    [N];
  logic [15:0] max_ed    [N];
  logic [7:0]  max_a     [N];
  logic [7:0]  max_b     [N];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    logic [15:0] prod;
    assign prod = 16'(op_a[i]) * 16'(op_b[i]);
    assign approx_y[i] = (i == 0) ? prod :
                         (i == 1 || i == 2) ? (prod & 16'hFFFE) :
                         (i == 3) ? 16'h0000 : 16'hFFFF;
    m8_error_monitor #(.ED_THRESH((i == 2) ? 1 : 0), .SUM_W(32)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_a      (op_a[i]),
      .op_b      (op_b[i]),
      .approx_y  (approx_y[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .err_count (err_count[i]),
      .sum_ed    (sum_ed[i]),
      .max_ed    (max_ed[i]),
      .max_a     (max_a[i]),
      .max_b     (max_b[i])
    );
  end

  // Final results after a full sweep.
  logic [16:0] fin_err [N] = '{17'd0, 17'd16384, 17'd0, 17'd65025, 17'd65536};
  logic [31:0] fin_sum [N] = '{32'd0, 32'd16384, 32'd16384, 32'd1065369600, 32'd3229532160};
  logic [15:0] fin_max [N] = '{16'd0, 16'd1, 16'd1, 16'd65025, 16'd65535};
  logic [7:0]  fin_a   [N] = '{8'd0, 8'd1, 8'd1, 8'd255, 8'd0};
  logic [7:0]  fin_b   [N] = '{8'd0, 8'd1, 8'd1, 8'd255, 8'd0};

  // Partial results visible in cycle T+300 (pairs k=0..296 accumulated).
  logic [16:0] mid_err [N] = '{17'd0, 17'd20, 17'd0, 17'd40, 17'd297};
  logic [31:0] mid_sum [N] = '{32'd0, 32'd20, 32'd20, 32'd820, 32'd19463075};
  logic [15:0] mid_max [N] = '{16'd0, 16'd1, 16'd1, 16'd40, 16'd65535};
  logic [7:0]  mid_a   [N] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd0};
  logic [7:0]  mid_b   [N] = '{8'd0, 8'd1, 8'd1, 8'd40, 8'd0};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_res(input int i, input string tag, input logic [16:0] e_err,
                         input logic [31:0] e_sum, input logic [15:0] e_max,
                         input logic [7:0] e_a, input logic [7:0] e_b);
    chk($sformatf("%s[%0d].err_count", tag, i), 64'(err_count[i]), 64'(e_err));
    chk($sformatf("%s[%0d].sum_ed", tag, i), 64'(sum_ed[i]), 64'(e_sum));
    chk($sformatf("%s[%0d].max_ed", tag, i), 64'(max_ed[i]), 64'(e_max));
    chk($sformatf("%s[%0d].max_a", tag, i), 64'(max_a[i]), 64'(e_a));
    chk($sformatf("%s[%0d].max_b", tag, i), 64'(max_b[i]), 64'(e_b));
  endtask

  task automatic chk_ctl(input int i, input string tag, input logic e_busy,
                         input logic e_done, input logic [15:0] e_ops);
    chk($sformatf("%s[%0d].busy", tag, i), 64'(busy[i]), 64'(e_busy));
    chk($sformatf("%s[%0d].done", tag, i), 64'(done[i]), 64'(e_done));
    chk($sformatf("%s[%0d].ops", tag, i), 64'({op_a[i], op_b[i]}), 64'(e_ops));
  endtask

  initial begin
    // Power-on reset.
    step(3);
    for (int i = 0; i < N; i++) begin
      chk_ctl(i, "reset", 1'b0, 1'b0, 16'h0000);
      chk_res(i, "reset", '0, '0, '0, '0, '0);
    end
    rst = 1'b0;
    step(2);

    // First sweep, aborted by reset; start sampled at the end of cycle T.
    start = 1'b1;
    step(1);                                   // cycle T+1
    start = 1'b0;
    for (int i = 0; i < N; i++) chk_ctl(i, "sweep1_first", 1'b1, 1'b0, 16'h0000);
    step(299);                                 // cycle T+300, k=299 presented
    for (int i = 0; i < N; i++) begin
      chk_ctl(i, "sweep1_t300", 1'b1, 1'b0, 16'h012B);
      chk_res(i, "sweep1_t300", mid_err[i], mid_sum[i], mid_max[i], mid_a[i], mid_b[i]);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk_ctl(i, "midreset", 1'b0, 1'b0, 16'h0000);
      chk_res(i, "midreset", '0, '0, '0, '0, '0);
    end
    step(3);
    for (int i = 0; i < N; i++) chk_ctl(i, "idle_hold", 1'b0, 1'b0, 16'h0000);

    // Full sweep with a second start at T+100 that must be ignored.
    start = 1'b1;
    step(1);                                   // T+1
    start = 1'b0;
    step(99);                                  // T+100
    start = 1'b1;
    step(1);                                   // T+101
    start = 1'b0;
    for (int i = 0; i < N; i++) chk_ctl(i, "ignored_start", 1'b1, 1'b0, 16'd100);
    step(65437);                               // T+65538, last DRAIN cycle
    for (int i = 0; i < N; i++) chk_ctl(i, "drain_last", 1'b1, 1'b0, 16'h0000);
    step(1);                                   // T+65539
    for (int i = 0; i < N; i++) begin
      chk_ctl(i, "done", 1'b0, 1'b1, 16'h0000);
      chk_res(i, "done", fin_err[i], fin_sum[i], fin_max[i], fin_a[i], fin_b[i]);
    end
    step(5);
    for (int i = 0; i < N; i++) begin
      chk_ctl(i, "done_hold", 1'b0, 1'b1, 16'h0000);
      chk_res(i, "done_hold", fin_err[i], fin_sum[i], fin_max[i], fin_a[i], fin_b[i]);
    end

    // Restart from DONE clears results and done.
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk_ctl(i, "restart", 1'b1, 1'b0, 16'h0000);
      chk_res(i, "restart", '0, '0, '0, '0, '0);
    end
    rst = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
